// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the writeback / register-file slice.
// Optional write-through bypass is selected with REGFILE_BYPASS_EN.
package writeback_regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // Index of the hardwired-zero register.
    localparam int unsigned ZERO_REG = 0;

    // Write-data select encoding carried on w_mem_to_reg.
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback-stage and decode-stage signals seen by the register file.
// The master is the pipeline (writeback + decode); the slave is the register file.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    // No valid/ready pair here: w_reg_write and d_issue_load are already-qualified
    // single-cycle requests, and the only backpressure is d_load_hazard towards decode.
    logic                  w_stall;
    logic [ADDR_WIDTH-1:0] w_dst_reg;
    logic                  w_reg_write;
    logic                  w_mem_to_reg;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [DATA_WIDTH-1:0] w_mem_data;

    logic [ADDR_WIDTH-1:0] d_rs_addr;
    logic [ADDR_WIDTH-1:0] d_rt_addr;
    logic [DATA_WIDTH-1:0] d_rs_data;
    logic [DATA_WIDTH-1:0] d_rt_data;
    logic                  d_issue_load;
    logic [ADDR_WIDTH-1:0] d_load_dst;
    logic                  d_rs_pending;
    logic                  d_rt_pending;
    logic                  d_load_hazard;

    modport master (
        output w_stall, w_dst_reg, w_reg_write, w_mem_to_reg, w_alu_result, w_mem_data,
        output d_rs_addr, d_rt_addr, d_issue_load, d_load_dst,
        input  d_rs_data, d_rt_data, d_rs_pending, d_rt_pending, d_load_hazard
    );

    modport slave (
        input  w_stall, w_dst_reg, w_reg_write, w_mem_to_reg, w_alu_result, w_mem_data,
        input  d_rs_addr, d_rt_addr, d_issue_load, d_load_dst,
        output d_rs_data, d_rt_data, d_rs_pending, d_rt_pending, d_load_hazard
    );

endinterface

// File: rtl/writeback_regfile_load_scoreboard.sv
// One pending bit per register for loads issued by decode but not yet written back.
// With REGFILE_BYPASS_EN the lookup hides a pending bit being cleared this cycle.
module load_scoreboard
    import writeback_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied before set so a load re-issued to the register that is
    // completing this cycle stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != ADDR_WIDTH'(ZERO_REG))) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rs_pending = pending_q[rs_addr] & ~(clr_en & (clr_idx == rs_addr));
    assign rt_pending = pending_q[rt_addr] & ~(clr_en & (clr_idx == rt_addr));
`else
    assign rs_pending = pending_q[rs_addr];
    assign rt_pending = pending_q[rt_addr];
`endif

endmodule

// File: rtl/writeback_regfile.sv
// Writeback commit into a 2**ADDR_WIDTH-entry register file with two combinational
// read ports and a pending-load scoreboard. Define REGFILE_BYPASS_EN for write-through reads.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic                clock,
    input logic                reset,
    writeback_regfile_if.slave bus
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  clr_en;
    logic                  rs_pending;
    logic                  rt_pending;

    assign wdata  = (bus.w_mem_to_reg == WB_SEL_MEM) ? bus.w_mem_data : bus.w_alu_result;
    // A stalled instruction is held upstream, so it commits once, when the stall drops.
    assign we     = bus.w_reg_write & ~bus.w_stall & (bus.w_dst_reg != ADDR_WIDTH'(ZERO_REG));
    assign clr_en = we & (bus.w_mem_to_reg == WB_SEL_MEM);

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[bus.w_dst_reg] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Register 0 is reset to zero and never written, so the array read alone keeps it zero.
`ifdef REGFILE_BYPASS_EN
    assign bus.d_rs_data = (we && (bus.d_rs_addr == bus.w_dst_reg)) ? wdata : regs_q[bus.d_rs_addr];
    assign bus.d_rt_data = (we && (bus.d_rt_addr == bus.w_dst_reg)) ? wdata : regs_q[bus.d_rt_addr];
`else
    assign bus.d_rs_data = regs_q[bus.d_rs_addr];
    assign bus.d_rt_data = regs_q[bus.d_rt_addr];
`endif

    load_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_load_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (bus.d_issue_load),
        .set_idx    (bus.d_load_dst),
        .clr_en     (clr_en),
        .clr_idx    (bus.w_dst_reg),
        .rs_addr    (bus.d_rs_addr),
        .rt_addr    (bus.d_rt_addr),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending)
    );

    assign bus.d_rs_pending  = rs_pending;
    assign bus.d_rt_pending  = rt_pending;
    assign bus.d_load_hazard = rs_pending | rt_pending;

endmodule
